// File: rtl/alt_mem_ddrx_input_if_buf.sv
// Buffered local input interface: command FIFO, write-beat credit tracking, init_done gating.
// Latency: accepted command shows on cmd_* the next cycle; write beats pass through combinationally.
// Backpressure: cmd ready drops on FIFO full / credit near max / !init_done_r; data ready needs credit.

// Generic synchronous FIFO with registered pointers and count.
// Latency: a pushed entry is visible on rdat one cycle after the push.
// Backpressure: caller must not push when full or pop when empty.
module alt_mem_ddrx_input_if_buf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdat,
  output logic [W-1:0] rdat,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Storage write; reset clears entries so the head is never undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdat  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
endmodule

module alt_mem_ddrx_input_if_buf #(
  parameter int CFG_LOCAL_DATA_WIDTH = 64,
  parameter int CFG_LOCAL_ID_WIDTH   = 8,
  parameter int CFG_LOCAL_ADDR_WIDTH = 33,
  parameter int CFG_LOCAL_SIZE_WIDTH = 3,
  parameter int CFG_CMD_FIFO_DEPTH   = 4,
  parameter int CFG_WR_CREDIT_WIDTH  = 8
) (
  input  logic                              ctl_clk,
  input  logic                              ctl_reset,
  input  logic                              init_done,
  input  logic                              itf_cmd_valid,
  output logic                              itf_cmd_ready,
  input  logic                              itf_cmd,
  input  logic [CFG_LOCAL_ADDR_WIDTH-1:0]   itf_cmd_address,
  input  logic [CFG_LOCAL_SIZE_WIDTH-1:0]   itf_cmd_burstlen,
  input  logic [CFG_LOCAL_ID_WIDTH-1:0]     itf_cmd_id,
  input  logic                              itf_cmd_priority,
  input  logic                              itf_wr_data_valid,
  output logic                              itf_wr_data_ready,
  input  logic [CFG_LOCAL_DATA_WIDTH-1:0]   itf_wr_data,
  input  logic [CFG_LOCAL_DATA_WIDTH/8-1:0] itf_wr_data_byte_en,
  input  logic [CFG_LOCAL_ID_WIDTH-1:0]     itf_wr_data_id,
  input  logic                              cmd_gen_full,
  output logic                              cmd_valid,
  output logic                              cmd_write,
  output logic                              cmd_read,
  output logic [CFG_LOCAL_ADDR_WIDTH-1:0]   cmd_address,
  output logic [CFG_LOCAL_SIZE_WIDTH-1:0]   cmd_size,
  output logic [CFG_LOCAL_ID_WIDTH-1:0]     cmd_id,
  output logic                              cmd_priority,
  input  logic                              wr_data_mem_full,
  output logic                              write_data_valid,
  output logic [CFG_LOCAL_DATA_WIDTH-1:0]   write_data,
  output logic [CFG_LOCAL_DATA_WIDTH/8-1:0] byte_en,
  output logic [CFG_LOCAL_ID_WIDTH-1:0]     write_data_id,
  output logic [CFG_WR_CREDIT_WIDTH-1:0]    wr_credit,
  output logic                              err_zero_burst
);
  typedef struct packed {
    logic                            write;
    logic [CFG_LOCAL_ADDR_WIDTH-1:0] addr;
    logic [CFG_LOCAL_SIZE_WIDTH-1:0] len;
    logic [CFG_LOCAL_ID_WIDTH-1:0]   id;
    logic                            prio;
  } cmd_ent_t;

  // Highest credit that still leaves room for a maximum-length burst.
  localparam logic [CFG_WR_CREDIT_WIDTH-1:0] CREDIT_LIMIT =
    {CFG_WR_CREDIT_WIDTH{1'b1}} - CFG_WR_CREDIT_WIDTH'((1 << CFG_LOCAL_SIZE_WIDTH) - 1);

  logic     init_done_r;
  logic     fifo_full;
  logic     fifo_empty;
  logic     credit_hi;
  logic     cmd_accept;
  logic     beat_accept;
  logic     pop;
  cmd_ent_t wr_ent;
  cmd_ent_t head;

  // Register init_done so the readies never depend on it combinationally.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) init_done_r <= 1'b0;
    else           init_done_r <= init_done;
  end

  assign credit_hi     = (wr_credit > CREDIT_LIMIT);
  assign itf_cmd_ready = init_done_r & ~fifo_full & ~credit_hi;
  assign cmd_accept    = itf_cmd_valid & itf_cmd_ready;

  assign wr_ent = '{write: itf_cmd, addr: itf_cmd_address, len: itf_cmd_burstlen,
                    id: itf_cmd_id, prio: itf_cmd_priority};

  assign pop = cmd_valid & ~cmd_gen_full;

  alt_mem_ddrx_input_if_buf_fifo #(
    .W     ($bits(cmd_ent_t)),
    .DEPTH (CFG_CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (ctl_clk),
    .rst   (ctl_reset),
    .push  (cmd_accept),
    .pop   (pop),
    .wdat  (wr_ent),
    .rdat  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Payload is masked by valid so an empty FIFO presents all-zero outputs.
  assign cmd_valid    = ~fifo_empty;
  assign cmd_write    = cmd_valid &  head.write;
  assign cmd_read     = cmd_valid & ~head.write;
  assign cmd_address  = cmd_valid ? head.addr : '0;
  assign cmd_size     = cmd_valid ? head.len  : '0;
  assign cmd_id       = cmd_valid ? head.id   : '0;
  assign cmd_priority = cmd_valid & head.prio;

  assign itf_wr_data_ready = init_done_r & ~wr_data_mem_full & (wr_credit != '0);
  assign beat_accept       = itf_wr_data_valid & itf_wr_data_ready;
  assign write_data_valid  = beat_accept;
  assign write_data        = itf_wr_data;
  assign byte_en           = itf_wr_data_byte_en;
  assign write_data_id     = itf_wr_data_id;

  // Credit grows by accepted write burst lengths and shrinks by one per accepted beat.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      wr_credit <= '0;
    end else begin
      wr_credit <= wr_credit
                 + ((cmd_accept && itf_cmd) ? CFG_WR_CREDIT_WIDTH'(itf_cmd_burstlen) : '0)
                 - CFG_WR_CREDIT_WIDTH'(beat_accept);
    end
  end

  // Sticky flag for any accepted zero-length command.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset)                                 err_zero_burst <= 1'b0;
    else if (cmd_accept && itf_cmd_burstlen == '0) err_zero_burst <= 1'b1;
  end
endmodule

// File: doc/alt_mem_ddrx_input_if_buf.md
Name: alt_mem_ddrx_input_if_buf

Overview:
Buffered successor to the controller's local input interface, placed between the local command/write-data channels and the command generator / write data path.
- Adds a parametrised-depth command FIFO, so local commands are decoupled from cmd_gen_full back-pressure.
- Adds a write-beat credit counter, so write data is only accepted for beats already promised by accepted write commands.
- Gates all local ready signals on a registered copy of init_done.

Parameters:
CFG_LOCAL_DATA_WIDTH, 64, local data bus width (multiple of 8)
CFG_LOCAL_ID_WIDTH, 8, command/data ID width
CFG_LOCAL_ADDR_WIDTH, 33, local address width
CFG_LOCAL_SIZE_WIDTH, 3, burst length field width; legal burstlen is 1..2^W-1
CFG_CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2, at least 2)
CFG_WR_CREDIT_WIDTH, 8, width of the outstanding-write-beat counter (must exceed CFG_LOCAL_SIZE_WIDTH)

Ports:
ctl_clk  in  1  controller clock
ctl_reset  in  1  asynchronous reset, active-high
init_done  in  1  memory initialisation complete
itf_cmd_valid  in  1  local command valid
itf_cmd_ready  out  1  local command accepted when high with valid
itf_cmd  in  1  1 = write, 0 = read
itf_cmd_address  in  CFG_LOCAL_ADDR_WIDTH  command address
itf_cmd_burstlen  in  CFG_LOCAL_SIZE_WIDTH  burst length in beats
itf_cmd_id  in  CFG_LOCAL_ID_WIDTH  command ID
itf_cmd_priority  in  1  priority flag
itf_wr_data_valid  in  1  write beat valid
itf_wr_data_ready  out  1  write beat accepted when high with valid
itf_wr_data  in  CFG_LOCAL_DATA_WIDTH  write data
itf_wr_data_byte_en  in  CFG_LOCAL_DATA_WIDTH/8  byte enables
itf_wr_data_id  in  CFG_LOCAL_ID_WIDTH  write data ID
cmd_gen_full  in  1  command generator back-pressure
cmd_valid  out  1  FIFO head valid
cmd_write  out  1  head is a write
cmd_read  out  1  head is a read
cmd_address  out  CFG_LOCAL_ADDR_WIDTH  head address
cmd_size  out  CFG_LOCAL_SIZE_WIDTH  head burst length
cmd_id  out  CFG_LOCAL_ID_WIDTH  head ID
cmd_priority  out  1  head priority
wr_data_mem_full  in  1  write data buffer back-pressure
write_data_valid  out  1  write beat forwarded
write_data  out  CFG_LOCAL_DATA_WIDTH  forwarded data
byte_en  out  CFG_LOCAL_DATA_WIDTH/8  forwarded byte enables
write_data_id  out  CFG_LOCAL_ID_WIDTH  forwarded ID
wr_credit  out  CFG_WR_CREDIT_WIDTH  outstanding write beats
err_zero_burst  out  1  sticky: a command with burstlen 0 was accepted

Behaviour:
Reset (asynchronous, ctl_reset high):
- FIFO empty; wr_credit = 0; init_done_r = 0; err_zero_burst = 0.
- All ready/valid outputs are 0; cmd_* payload outputs are 0.

init_done_r:
- init_done_r is init_done registered once.
- When init_done falls mid-operation, both readies drop on the next cycle. FIFO contents keep draining and wr_credit is preserved.

Command path:
- cmd_accept = itf_cmd_valid & itf_cmd_ready.
- itf_cmd_ready = init_done_r & ~fifo_full & ~credit_hi.
- credit_hi = wr_credit > 2^CFG_WR_CREDIT_WIDTH-1 - (2^CFG_LOCAL_SIZE_WIDTH-1). It is evaluated regardless of command type, so the credit counter never overflows.
- The FIFO stores {itf_cmd, address, burstlen, id, priority}. Read pointer, write pointer and count are registered.
- cmd_valid = ~fifo_empty. cmd_write = cmd_valid & head.itf_cmd. cmd_read = cmd_valid & ~head.itf_cmd.
- Pop when cmd_valid & ~cmd_gen_full.
- Latency: a command accepted in cycle N appears on cmd_* in cycle N+1. There is no combinational bypass.
- Push and pop in the same cycle leave the count unchanged.
- Full blocks push even if a pop occurs that cycle (ready is derived from registered full only).
- Pointers wrap modulo CFG_CMD_FIFO_DEPTH.
- cmd_gen_full high holds the head stable.

Write credit:
- On cmd_accept with itf_cmd=1, add burstlen. On each write beat accepted, subtract 1. Both in the same cycle give credit + burstlen - 1.
- burstlen 0 is forwarded unchanged, adds 0 credit, and sets err_zero_burst. err_zero_burst clears only on reset.

Write data path:
- itf_wr_data_ready = init_done_r & ~wr_data_mem_full & (wr_credit != 0).
- A write command and its data accepted in the same cycle: the data waits one cycle, because credit is registered.
- write_data_valid = itf_wr_data_valid & itf_wr_data_ready.
- write_data, byte_en and write_data_id are combinational pass-through of the itf_wr_data_* inputs. They carry zero additional latency.

Test Plan:
1. Reset, init_done=0, drive itf_cmd_valid and itf_wr_data_valid -> both readies stay 0. Set init_done=1 at cycle 5 -> itf_cmd_ready=1 at cycle 6.
2. DEPTH=4, cmd_gen_full=1, push 5 reads -> 4 accepted, itf_cmd_ready=0 on the 5th. Release cmd_gen_full -> 4 cmd_read pulses in order, IDs 0..3, one per cycle.
3. Write with burstlen=4, then 4 data beats offered back-to-back -> wr_credit goes 4,3,2,1,0. A 5th beat is refused (ready=0).
4. Write burstlen=2 accepted in the same cycle as the last beat of a previous burst (credit=1) -> credit becomes 2, with no lost or extra beat.
5. Drop init_done with 2 commands in the FIFO and credit=3 -> readies drop the next cycle, FIFO drains both commands, wr_credit stays 3.
6. Accept a command with burstlen=0 -> it is forwarded with cmd_size=0, err_zero_burst=1 sticks, wr_credit unchanged. Assert ctl_reset mid-burst -> all state cleared immediately.
